// File: rtl/codec_cfg_pkg.sv
// Shared types and the default codec register table for the power-up configuration sequencer.
// Each table word is {7-bit register address, 9-bit value}.
package codec_cfg_pkg;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_DELAY    = 4'd1,
      ST_LOAD     = 4'd2,
      ST_SEND     = 4'd3,
      ST_WAIT_END = 4'd4,
      ST_RELEASE  = 4'd5,
      ST_GAP      = 4'd6,
      ST_DONE     = 4'd7,
      ST_ERROR    = 4'd8
   } cfg_state_e;

   localparam logic [6:0] LINE_IN_L = 7'h00;
   localparam logic [6:0] LINE_IN_R = 7'h01;
   localparam logic [6:0] HP_OUT_L  = 7'h02;
   localparam logic [6:0] HP_OUT_R  = 7'h03;
   localparam logic [6:0] ANA_PATH  = 7'h04;
   localparam logic [6:0] DIG_PATH  = 7'h05;
   localparam logic [6:0] PWR_DN    = 7'h06;
   localparam logic [6:0] DAI_FMT   = 7'h07;
   localparam logic [6:0] SMP_CTRL  = 7'h08;
   localparam logic [6:0] ACTIVE    = 7'h09;
   localparam logic [6:0] RESET_REG = 7'h0F;

   // Entries 10..15 are only reached when a build raises NUM_WORDS.
   localparam logic [15:0] CFG_TABLE [16] = '{
      {RESET_REG, 9'h000},
      {PWR_DN,    9'h000},
      {LINE_IN_L, 9'h017},
      {LINE_IN_R, 9'h017},
      {HP_OUT_L,  9'h079},
      {HP_OUT_R,  9'h079},
      {ANA_PATH,  9'h012},
      {DAI_FMT,   9'h002},
      {SMP_CTRL,  9'h000},
      {ACTIVE,    9'h001},
      {DIG_PATH,  9'h000},
      {ACTIVE,    9'h001},
      {ACTIVE,    9'h001},
      {ACTIVE,    9'h001},
      {ACTIVE,    9'h001},
      {ACTIVE,    9'h001}
   };

endpackage

// File: rtl/codec_cfg_rom.sv
// Index-to-word lookup over the codec configuration table; swap this module for alternate tables.
module codec_cfg_rom
   import codec_cfg_pkg::*;
(
   input  logic [3:0]  idx_i,
   output logic [15:0] word_o
);

   assign word_o = CFG_TABLE[idx_i];

endmodule

// File: rtl/codec_cfg_seq.sv
// Codec power-up configuration sequencer: sends table words to the I2C stage via GO/END.
// Optional NACK retry path enabled with `define CODEC_CFG_RETRY_EN.
//
// state    | meaning
// IDLE     | first cycle after reset, loads start delay
// DELAY    | waiting START_DELAY cycles
// LOAD     | latch table word word_idx into i2c_data
// SEND     | arm timeout, raise go
// WAIT_END | go held, waiting for end_i (timeout running)
// RELEASE  | go dropped, waiting for end_i low
// GAP      | idle GAP_CYCLES, then next word / retry / finish
// DONE     | all words ACKed
// ERROR    | NACK beyond retries or timeout
module codec_cfg_seq
   import codec_cfg_pkg::*;
#(
   parameter int NUM_WORDS   = 10,
   parameter int START_DELAY = 1000,
   parameter int GAP_CYCLES  = 64,
   parameter int MAX_RETRY   = 3,
   parameter int TIMEOUT     = 200000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        restart,
   input  logic        end_i,
   input  logic        ack,
   output logic [15:0] i2c_data,
   output logic        go,
   output logic [3:0]  word_idx,
   output logic        cfg_done,
   output logic        cfg_err
);

   if (NUM_WORDS < 1 || NUM_WORDS > 16 || START_DELAY < 1 || GAP_CYCLES < 1 ||
       TIMEOUT < 1 || MAX_RETRY < 0) begin : g_param_check
      $error("codec_cfg_seq: parameter out of range");
   end

   localparam int CNT_MAX = (TIMEOUT > START_DELAY) ?
                            ((TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES) :
                            ((START_DELAY > GAP_CYCLES) ? START_DELAY : GAP_CYCLES);
   localparam int CW = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] DELAY_LOAD = CW'(START_DELAY - 1);
   localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] TMO_LOAD   = CW'(TIMEOUT - 1);
   localparam logic [3:0]    LAST_IDX   = 4'(NUM_WORDS - 1);

   cfg_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    idx_q, idx_d;
   logic [15:0]   data_q, data_d;
   logic          ack_q, ack_d;
   logic          go_q, go_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [15:0]   rom_word;

`ifdef CODEC_CFG_RETRY_EN
   localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
   logic [RW-1:0] retry_q, retry_d;
`endif

   codec_cfg_rom u_rom (
      .idx_i  (idx_q),
      .word_o (rom_word)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         ack_q   <= 1'b0;
         go_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         ack_q   <= ack_d;
         go_q    <= go_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

`ifdef CODEC_CFG_RETRY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) retry_q <= '0;
      else       retry_q <= retry_d;
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      data_d  = data_q;
      ack_d   = ack_q;
`ifdef CODEC_CFG_RETRY_EN
      retry_d = retry_q;
`endif

      case (state_q)
         ST_IDLE: begin
            cnt_d   = DELAY_LOAD;
            state_d = ST_DELAY;
         end
         ST_DELAY: begin
            if (cnt_q == '0) state_d = ST_LOAD;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_LOAD: begin
            data_d  = rom_word;
            state_d = ST_SEND;
         end
         ST_SEND: begin
            cnt_d   = TMO_LOAD;
            state_d = ST_WAIT_END;
         end
         ST_WAIT_END: begin
            // end_i takes priority over the timeout terminal count
            if (end_i) begin
               ack_d   = ack;
               state_d = ST_RELEASE;
            end else if (cnt_q == '0) begin
               state_d = ST_ERROR;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RELEASE: begin
            if (!end_i) begin
               cnt_d   = GAP_LOAD;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (ack_q) begin
`ifdef CODEC_CFG_RETRY_EN
               retry_d = '0;
`endif
               if (idx_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = ST_LOAD;
               end
            end else begin
`ifdef CODEC_CFG_RETRY_EN
               if (retry_q == RETRY_LIMIT) begin
                  state_d = ST_ERROR;
               end else begin
                  retry_d = retry_q + 1'b1;
                  state_d = ST_LOAD;
               end
`else
               state_d = ST_ERROR;
`endif
            end
         end
         ST_DONE, ST_ERROR: begin
            if (restart) begin
               idx_d   = '0;
`ifdef CODEC_CFG_RETRY_EN
               retry_d = '0;
`endif
               state_d = ST_LOAD;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are registered copies of the next-state decode.
      go_d   = (state_d == ST_WAIT_END);
      done_d = (state_d == ST_DONE);
      err_d  = (state_d == ST_ERROR);
   end

   assign i2c_data = data_q;
   assign go       = go_q;
   assign word_idx = idx_q;
   assign cfg_done = done_q;
   assign cfg_err  = err_q;

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Self-checking bench for codec_cfg_seq: I2C stage responder, transmit log and a word-level reference model.
module tb_codec_cfg_seq;

   localparam int NW = 10;
   localparam int SD = 20;
   localparam int GC = 8;
   localparam int MR = 3;
   localparam int TO = 300;
`ifdef CODEC_CFG_RETRY_EN
   localparam int R_EFF = MR;
`else
   localparam int R_EFF = 0;
`endif

   localparam logic [15:0] EXP_TBL [NW] = '{
      16'h1E00, 16'h0C00, 16'h0017, 16'h0217, 16'h0479,
      16'h0679, 16'h0812, 16'h0E02, 16'h1000, 16'h1201
   };

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        restart = 1'b0;
   logic        end_i = 1'b0;
   logic        ack = 1'b0;
   logic [15:0] i2c_data;
   logic        go;
   logic [3:0]  word_idx;
   logic        cfg_done;
   logic        cfg_err;

   always #5 clk = ~clk;

   codec_cfg_seq #(
      .NUM_WORDS   (NW),
      .START_DELAY (SD),
      .GAP_CYCLES  (GC),
      .MAX_RETRY   (MR),
      .TIMEOUT     (TO)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .restart  (restart),
      .end_i    (end_i),
      .ack      (ack),
      .i2c_data (i2c_data),
      .go       (go),
      .word_idx (word_idx),
      .cfg_done (cfg_done),
      .cfg_err  (cfg_err)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Stimulus controls (written only by the main sequence)
   int nack_plan [NW];
   int run_id = 0;
   bit never_end = 1'b0;
   bit rand_lat = 1'b0;

   // Responder / monitor state (written only by the responder)
   logic [15:0] tx_q [$];
   int nack_cnt [NW];
   int seen_run = 0;
   int lat_cnt = 0;
   int cur_lat = 40;
   bit go_prev = 1'b0;
   logic [15:0] data_hold = 16'h0;
   int stab_err = 0;
   int end_rise_cyc = 0;
   int end_fall_cyc = 0;
   bit fall_valid = 1'b0;
   int gap_meas = -1;
   int drop_meas = -1;

   always @(negedge clk) begin
      if (seen_run != run_id) begin
         for (int i = 0; i < NW; i++) nack_cnt[i] = 0;
         seen_run = run_id;
      end
      if (reset) begin
         end_i = 1'b0;
         ack = 1'b0;
         lat_cnt = 0;
         go_prev = 1'b0;
         fall_valid = 1'b0;
      end else begin
         if (go && !go_prev) begin
            tx_q.push_back(i2c_data);
            data_hold = i2c_data;
            if (fall_valid) gap_meas = cyc - end_fall_cyc;
            fall_valid = 1'b0;
         end
         if (!go && go_prev && end_i) drop_meas = cyc - end_rise_cyc;
         if (go && !end_i && i2c_data !== data_hold) stab_err++;
         go_prev = go;
         if (go && !end_i && !never_end) begin
            lat_cnt++;
            if (lat_cnt >= cur_lat) begin
               int wi;
               wi = int'(word_idx);
               end_i = 1'b1;
               end_rise_cyc = cyc;
               lat_cnt = 0;
               if (wi < NW && nack_cnt[wi] < nack_plan[wi]) begin
                  ack = 1'b0;
                  nack_cnt[wi]++;
               end else begin
                  ack = 1'b1;
               end
               cur_lat = rand_lat ? int'($urandom_range(1, 40)) : 40;
            end
         end else if (!go && end_i) begin
            end_i = 1'b0;
            ack = 1'b0;
            end_fall_cyc = cyc;
            fall_valid = 1'b1;
         end
      end
   end

   // Reference model: word-level expectation from the NACK plan
   logic [15:0] exp_q [$];
   bit exp_done, exp_err;
   int exp_idx;

   function automatic void build_exp();
      exp_q.delete();
      exp_done = 1'b0;
      exp_err = 1'b0;
      exp_idx = 0;
      for (int i = 0; i < NW; i++) begin
         int sends;
         sends = (nack_plan[i] > R_EFF) ? R_EFF + 1 : nack_plan[i] + 1;
         for (int k = 0; k < sends; k++) exp_q.push_back(EXP_TBL[i]);
         exp_idx = i;
         if (nack_plan[i] > R_EFF) begin
            exp_err = 1'b1;
            break;
         end
      end
      if (!exp_err) exp_done = 1'b1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic compare_run(input string name, input int base);
      int got;
      got = tx_q.size() - base;
      chk({name, "_count"}, got, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got; i++)
         chk($sformatf("%s_word%0d", name, i), {16'h0, tx_q[base + i]}, {16'h0, exp_q[i]});
      chk({name, "_done"}, cfg_done, exp_done);
      chk({name, "_err"}, cfg_err, exp_err);
      chk({name, "_idx"}, word_idx, exp_idx);
   endtask

   task automatic wait_final();
      int n;
      n = 0;
      while (!(cfg_done || cfg_err) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk("run_finish", cfg_done | cfg_err, 1);
   endtask

   task automatic do_restart(input string name);
      int n;
      @(negedge clk);
      restart = 1'b1;
      @(posedge clk);
      #1 restart = 1'b0;
      chk({name, "_done_clr"}, cfg_done, 0);
      chk({name, "_err_clr"}, cfg_err, 0);
      n = 1;
      while (!go && n < 50) begin
         @(posedge clk);
         #1 n++;
      end
      chk({name, "_restart_lat"}, n, 3);
   endtask

   initial begin
      int base;
      int n;

      for (int i = 0; i < NW; i++) nack_plan[i] = 0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_go", go, 0);
      chk("rst_data", i2c_data, 0);
      chk("rst_idx", word_idx, 0);
      chk("rst_done", cfg_done, 0);
      chk("rst_err", cfg_err, 0);

      // Basic run, fixed 40-cycle latency, always ACK
      base = tx_q.size();
      reset = 1'b0;
      n = 0;
      while (!go && n < SD + 50) begin
         @(posedge clk);
         #1 n++;
      end
      chk("first_go_lat", n, SD + 3);
      chk("first_word", i2c_data, 16'h1E00);
      wait_final();
      build_exp();
      compare_run("basic", base);
      if (tx_q.size() > 0) chk("last_word", tx_q[tx_q.size() - 1], 16'h1201);
      chk("go_drop_lat", drop_meas, 1);
      chk("gap_lat", gap_meas, GC + 3);
      chk("data_stable", stab_err, 0);

      // Restart from DONE; a restart pulse in WAIT_END must be ignored
      run_id++;
      rand_lat = 1'b1;
      base = tx_q.size();
      do_restart("rerun");
      n = 0;
      while (!((tx_q.size() - base) >= 3 && go) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      chk("mid_done_low", cfg_done, 0);
      wait_final();
      build_exp();
      compare_run("restart_ign", base);

      // Word 3 NACKed twice
      run_id++;
      nack_plan[3] = 2;
      base = tx_q.size();
      do_restart("nack3");
      wait_final();
      build_exp();
      compare_run("nack3", base);

      // Word 5 always NACKs
      run_id++;
      nack_plan[3] = 0;
      nack_plan[5] = 1000;
      base = tx_q.size();
      do_restart("nack5");
      wait_final();
      build_exp();
      compare_run("nack5", base);

      // Randomized NACK plans
      for (int r = 0; r < 3; r++) begin
         run_id++;
         for (int i = 0; i < NW; i++)
            nack_plan[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, R_EFF + 1)) : 0;
         base = tx_q.size();
         do_restart($sformatf("rand%0d", r));
         wait_final();
         build_exp();
         compare_run($sformatf("rand%0d", r), base);
      end

      // end_i never rises: go held exactly TIMEOUT cycles, then error
      run_id++;
      for (int i = 0; i < NW; i++) nack_plan[i] = 0;
      never_end = 1'b1;
      do_restart("tmo");
      n = 0;
      while (go && n < TO + 20) begin
         n++;
         @(posedge clk);
         #1;
      end
      chk("tmo_go_cycles", n, TO);
      chk("tmo_err", cfg_err, 1);
      chk("tmo_done", cfg_done, 0);
      chk("tmo_idx", word_idx, 0);
      never_end = 1'b0;

      // Asynchronous reset while word 4 is in flight
      run_id++;
      do_restart("rst4");
      n = 0;
      while (!(word_idx == 4'd4 && go) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      #2 reset = 1'b1;
      #1;
      chk("rst4_go", go, 0);
      chk("rst4_idx", word_idx, 0);
      chk("rst4_data", i2c_data, 0);
      @(negedge clk);
      base = tx_q.size();
      reset = 1'b0;
      n = 0;
      while (!go && n < SD + 50) begin
         @(posedge clk);
         #1 n++;
      end
      chk("rst4_go_lat", n, SD + 3);
      wait_final();
      build_exp();
      compare_run("rst4_rerun", base);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/codec_cfg_seq.md
# codec_cfg_seq

Power-up configuration sequencer for the audio codec control port. Walks a fixed table of 16-bit codec register words (7-bit register address, 9-bit value) and hands each word to the I2C transmit stage through the GO/END handshake, checking the acknowledge after every transaction. Sits directly upstream of the I2C/audio interface block. It drives that block's `i2c_DATA` and `GO` inputs and consumes its `END` and `ack` outputs. The audio datapath is held off until `cfg_done` rises.

## Interface
- `NUM_WORDS`, 10: number of table entries sent, 1..16.
- `START_DELAY`, 1000: `clk` cycles waited after reset release before the first word.
- `GAP_CYCLES`, 64: idle `clk` cycles between consecutive transactions.
- `MAX_RETRY`, 3: resends of one word after NACK. Used only with `CODEC_CFG_RETRY_EN`.
- `TIMEOUT`, 200000: `clk` cycles allowed for `end_i` to rise after `go`.

- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `restart` input 1: one-cycle pulse. Reruns the whole table from word 0. Honoured only in DONE or ERROR.
- `end_i` input 1: transaction complete, from the I2C stage. Level, high until `go` drops.
- `ack` input 1: valid while `end_i` is high. 1 means all three bytes were ACKed.
- `i2c_data` output 16: register word. Stable from `go` rise until `end_i` rise.
- `go` output 1: request to the I2C stage. Level.
- `word_idx` output 4: index of the word in flight.
- `cfg_done` output 1: all words ACKed. Sticky until reset or `restart`.
- `cfg_err` output 1: table aborted (NACK beyond retries, or timeout). Sticky until reset or `restart`.

## Operation
- States:
  - IDLE: one cycle after reset; loads the delay counter.
  - DELAY: counts `START_DELAY`, then goes to LOAD.
  - LOAD: latches table word `word_idx` into `i2c_data`.
  - SEND: asserts `go`.
  - WAIT_END: holds `go`. On `end_i`=1, samples `ack` and goes to RELEASE.
  - RELEASE: drops `go` and waits for `end_i`=0.
  - GAP: counts `GAP_CYCLES`.
  - DONE.
  - ERROR.
- WAIT_END with `ack`=1: after RELEASE and GAP, increments `word_idx`.
  - If `word_idx` was `NUM_WORDS`-1, goes to DONE instead.
- WAIT_END with `ack`=0: goes to RELEASE, then GAP, then resends the same word (retry path) or goes to ERROR.
- Timeout counter runs during WAIT_END. Reaching `TIMEOUT` drops `go` and goes to ERROR.
- DONE sets `cfg_done`. ERROR sets `cfg_err`. `word_idx` freezes at the failing or last index.
- `restart` in DONE or ERROR:
  - clears `cfg_done` and `cfg_err`, zeroes `word_idx` and the retry counter;
  - goes to LOAD, skipping DELAY.
- `restart` in any other state is ignored.
- The retry counter resets on every ACKed word.

## Timing
- Reset values: `go`=0, `i2c_data`=16'h0000, `word_idx`=0, `cfg_done`=0, `cfg_err`=0. State = IDLE.
- First `go` rises `START_DELAY`+3 cycles after `reset` falls: IDLE, DELAY×`START_DELAY`, LOAD, SEND.
- `go` rises the cycle after LOAD. `i2c_data` is already valid in that cycle.
- `go` falls the cycle after `end_i` is first sampled high.
- Next word's `go` rises `GAP_CYCLES`+2 cycles after `end_i` is sampled low.
- `end_i` high in the same cycle as the timeout terminal count: `end_i` wins and `ack` is evaluated.
- `reset` mid-transaction drops `go` immediately (asynchronous) and the sequence restarts from DELAY.
- No outputs are combinational from inputs. All outputs are registered.

## Configuration
- `CODEC_CFG_RETRY_EN` defined:
  - NACK resends the same word, up to `MAX_RETRY` times.
  - The (`MAX_RETRY`+1)-th consecutive NACK goes to ERROR.
- `CODEC_CFG_RETRY_EN` undefined:
  - the first NACK goes to ERROR;
  - no retry counter is synthesized and `MAX_RETRY` is ignored.

## Structure
- Package `codec_cfg_pkg` holds:
  - the state enum;
  - register address constants: LINE_IN_L, LINE_IN_R, HP_OUT_L, HP_OUT_R, ANA_PATH, DIG_PATH, PWR_DN, DAI_FMT, SMP_CTRL, ACTIVE, RESET_REG;
  - the 16-entry default word table as a constant array.
- Table order:
  - RESET_REG write (16'h1E00) first;
  - DAI_FMT: I2S, 16-bit, slave;
  - ACTIVE (16'h1201) last.
- Sub-module `codec_cfg_rom`: combinational index → word lookup over the package table. Kept separate so alternate tables can be swapped in.

## Test plan
- Basic run, I2C model always ACKs (`end_i` 40 cycles after `go`):
  - exactly `NUM_WORDS` `go` pulses;
  - first word 16'h1E00, last 16'h1201;
  - `cfg_done`=1, `cfg_err`=0.
- Word 3 NACKed twice, then ACKed, with `CODEC_CFG_RETRY_EN`:
  - word 3 sent three times, then completes;
  - with the macro undefined: `cfg_err`=1, `word_idx`=3.
- Word 5 always NACKs, retry enabled, `MAX_RETRY`=3:
  - 4 transmissions of word 5, then `cfg_err`=1;
  - no word 6 is ever sent.
- `end_i` never rises: `go` drops and `cfg_err`=1 exactly `TIMEOUT` cycles into WAIT_END.
- `reset` pulsed while `go`=1 on word 4:
  - `go`=0 in the same cycle;
  - rerun starts at word 0 after `START_DELAY`.
- `restart` pulsed during WAIT_END: ignored. `restart` in DONE: full table resent with no DELAY; `cfg_done` low until completion.
